char_buffer: RTL

Parametrised character buffer holding DEPTH display characters for the text print path. Adds cursor-based append writes, optional scroll-by-one on print completion, and a multi-cycle clear sweep on top of random-address writes. The full buffer is exported as one flat bus to the character renderer; slot 0 occupies the most significant character position.

---
 rtl/char_buffer.sv | 93 +++++++++
 1 files changed

// File: rtl/char_buffer.sv
// Character buffer for the text print path: random writes, cursor appends,
// scroll-by-one on frame end, and a one-slot-per-cycle clear sweep.
module char_buffer #(
  parameter int unsigned   DEPTH     = 64,
  parameter int unsigned   AW        = 6,
  parameter int unsigned   CW        = 8,
  parameter logic [CW-1:0] NULL_CHAR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CW-1:0]       din,
  input  logic                push,
  input  logic [CW-1:0]       push_data,
  input  logic                scroll_en,
  input  logic                print_fin,
  input  logic                clr,
  output logic [DEPTH*CW-1:0] dout,
  output logic [AW-1:0]       cursor,
  output logic                busy
);

  localparam logic [AW-1:0] LastSlot = AW'(DEPTH - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e        state;
  logic [AW-1:0] sweep_idx;
  logic [CW-1:0] slot_q [DEPTH];
  logic          idle_update;
  logic          rotate;

  // Inputs only act in IDLE, and clr pre-empts everything on its own edge.
  assign idle_update = (state == StIdle) && !clr;
  assign rotate      = idle_update && print_fin && scroll_en;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [CW-1:0] q;
    logic [CW-1:0] nxt;

    assign slot_q[g] = q;
    assign dout[(DEPTH-g)*CW-1 -: CW] = q;

    // Later assignments override earlier ones: rotate, then push, then write.
    always_comb begin
      nxt = q;
      if (state == StClear) begin
        if (sweep_idx == AW'(g)) nxt = NULL_CHAR;
      end else if (idle_update) begin
        if (rotate) nxt = slot_q[(g + 1) % DEPTH];
        if (push && cursor == AW'(g)) nxt = push_data;
        if (we && wr_addr == AW'(g)) nxt = din;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= NULL_CHAR;
      else     q <= nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      busy      <= 1'b0;
      cursor    <= '0;
      sweep_idx <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (clr) begin
            state     <= StClear;
            busy      <= 1'b1;
            cursor    <= '0;
            sweep_idx <= '0;
          end else if (push) begin
            cursor <= (cursor == LastSlot) ? '0 : cursor + AW'(1);
          end
        end
        StClear: begin
          if (sweep_idx == LastSlot) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + AW'(1);
          end
        end
      endcase
    end
  end

endmodule
